// File: rtl/scoreboard_regfile.sv
// Register file with a per-register pending scoreboard and a self-clearing init sweep after reset.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module scoreboard_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_num,
  input  logic [AW-1:0]   rs2_num,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_num,
  input  logic            wr_en,
  input  logic [AW-1:0]   rd_num,
  input  logic [XLEN-1:0] wr_data,
  output logic            ready,
  output logic            pending_any
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    pending_d = pending_q;
    regs_d    = regs_q;
    case (state_q)
      ST_INIT: begin
        regs_d[clr_cnt_q] = '0;
        clr_cnt_d         = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(NREGS - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wr_en && rd_num != '0) begin
          regs_d[rd_num]    = wr_data;
          pending_d[rd_num] = 1'b0;
        end
        // Issue is applied after writeback so a same-cycle new producer keeps the bit set.
        if (iss_en && iss_num != '0) pending_d[iss_num] = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      pending_q <= pending_d;
    end
  end

  // Array contents are not reset; the INIT sweep zeroes them instead.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  logic [AW-1:0]   rs_num  [2];
  logic [XLEN-1:0] rs_data [2];
  logic            rs_busy [2];

  assign rs_num[0] = rs1_num;
  assign rs_num[1] = rs2_num;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data[p] = '0;
      rs_busy[p] = 1'b0;
      if (state_q == ST_RUN && rs_num[p] != '0) begin
        rs_data[p] = regs_q[rs_num[p]];
        rs_busy[p] = pending_q[rs_num[p]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && rd_num == rs_num[p]) begin
          rs_data[p] = wr_data;
          if (!(iss_en && iss_num == rs_num[p])) rs_busy[p] = 1'b0;
        end
`endif
      end
    end
  end

  assign rs1_data    = rs_data[0];
  assign rs2_data    = rs_data[1];
  assign rs1_busy    = rs_busy[0];
  assign rs2_busy    = rs_busy[1];
  assign ready       = (state_q == ST_RUN);
  assign pending_any = |pending_q;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed self-checking bench for scoreboard_regfile (default parameters).
module tb_scoreboard_regfile;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1_num, rs2_num, iss_num, rd_num;
  logic [XLEN-1:0] rs1_data, rs2_data, wr_data;
  logic            rs1_busy, rs2_busy, iss_en, wr_en, ready, pending_any;

  int checks = 0;
  int errors = 0;

  scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_num(rs1_num), .rs2_num(rs2_num),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .iss_en(iss_en), .iss_num(iss_num),
    .wr_en(wr_en), .rd_num(rd_num), .wr_data(wr_data),
    .ready(ready), .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset just after an edge and count NREGS edges to ready.
  // While INIT runs, strobes are driven to prove they are ignored.
  task automatic release_and_init(input string tag);
    rst_n   = 1'b1;
    iss_en  = 1'b1; iss_num = 5'd4;
    wr_en   = 1'b1; rd_num  = 5'd4; wr_data = 32'hFFFF_FFFF;
    rs1_num = 5'd9;
    for (int k = 1; k <= NREGS; k++) begin
      tick();
      if (k == 2) begin
        check({tag, "_init_rs1_data"}, rs1_data, 32'h0);
        check({tag, "_init_rs1_busy"}, {31'h0, rs1_busy}, 32'h0);
      end
      if (k == NREGS - 1) check({tag, "_ready_lo"}, {31'h0, ready}, 32'h0);
      if (k == NREGS) begin
        iss_en = 1'b0; wr_en = 1'b0;
        check({tag, "_ready_hi"}, {31'h0, ready}, 32'h1);
      end
    end
    #1;
    check({tag, "_pend_after_init"}, {31'h0, pending_any}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; iss_en = 1'b0; wr_en = 1'b0;
    rs1_num = '0; rs2_num = '0; iss_num = '0; rd_num = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_pend",  {31'h0, pending_any}, 32'h0);
    check("rst_rs1_data", rs1_data, 32'h0);
    check("rst_rs2_busy", {31'h0, rs2_busy}, 32'h0);

    release_and_init("init0");
    for (int i = 0; i < NREGS; i++) begin
      rs1_num = AW'(i); rs2_num = AW'(NREGS - 1 - i);
      #1;
      check("clr_rs1", rs1_data, 32'h0);
      check("clr_rs2", rs2_data, 32'h0);
    end

    // Write x5 and attempted write of x0.
    rs1_num = 5'd5; rs2_num = 5'd0;
    wr_en = 1'b1; rd_num = 5'd5; wr_data = 32'hDEAD_BEEF;
    tick();
    rd_num = 5'd0; wr_data = 32'h1234_5678;
    tick();
    wr_en = 1'b0;
    #1;
    check("x5_data", rs1_data, 32'hDEAD_BEEF);
    check("x0_data", rs2_data, 32'h0);

    // Issue x7, write it back three cycles later.
    iss_en = 1'b1; iss_num = 5'd7; rs1_num = 5'd7;
    tick();
    iss_en = 1'b0;
    check("x7_busy", {31'h0, rs1_busy}, 32'h1);
    check("x7_pend", {31'h0, pending_any}, 32'h1);
    tick(); tick();
    check("x7_busy_hold", {31'h0, rs1_busy}, 32'h1);
    wr_en = 1'b1; rd_num = 5'd7; wr_data = 32'hA5A5_A5A5;
    tick();
    wr_en = 1'b0;
    #1;
    check("x7_busy_clr", {31'h0, rs1_busy}, 32'h0);
    check("x7_pend_clr", {31'h0, pending_any}, 32'h0);
    check("x7_data", rs1_data, 32'hA5A5_A5A5);

    // Issue to x0 sets nothing.
    iss_en = 1'b1; iss_num = 5'd0; rs1_num = 5'd0;
    tick();
    iss_en = 1'b0;
    check("x0_iss_pend", {31'h0, pending_any}, 32'h0);
    check("x0_iss_busy", {31'h0, rs1_busy}, 32'h0);

    // Same-cycle issue and write on x9: set wins.
    iss_en = 1'b1; iss_num = 5'd9; wr_en = 1'b1; rd_num = 5'd9; wr_data = 32'h55;
    rs1_num = 5'd9;
    tick();
    iss_en = 1'b0; wr_en = 1'b0;
    #1;
    check("x9_data", rs1_data, 32'h55);
    check("x9_busy", {31'h0, rs1_busy}, 32'h1);
    check("x9_pend", {31'h0, pending_any}, 32'h1);

    // x3 = 0x11, issued, then written 0x77 while rs2 reads it.
    wr_en = 1'b1; rd_num = 5'd3; wr_data = 32'h11;
    tick();
    wr_en = 1'b0; iss_en = 1'b1; iss_num = 5'd3;
    tick();
    iss_en = 1'b0;
    rs2_num = 5'd3; wr_en = 1'b1; rd_num = 5'd3; wr_data = 32'h77;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x3_byp_data", rs2_data, 32'h77);
    check("x3_byp_busy", {31'h0, rs2_busy}, 32'h0);
    iss_en = 1'b1; iss_num = 5'd3;
    #1;
    check("x3_byp_iss_busy", {31'h0, rs2_busy}, 32'h1);
    iss_en = 1'b0;
`else
    check("x3_nobyp_data", rs2_data, 32'h11);
    check("x3_nobyp_busy", {31'h0, rs2_busy}, 32'h1);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    check("x3_data", rs2_data, 32'h77);
    check("x3_busy", {31'h0, rs2_busy}, 32'h0);

    // Reset in INIT at clr_cnt=10.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("midinit_ready", {31'h0, ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midinit_pend", {31'h0, pending_any}, 32'h0);
    tick();
    release_and_init("init1");
    rs1_num = 5'd5;
    #1;
    check("init1_x5", rs1_data, 32'h0);

    // Reset in RUN with x4 pending.
    iss_en = 1'b1; iss_num = 5'd4; rs1_num = 5'd4;
    tick();
    iss_en = 1'b0;
    check("x4_busy", {31'h0, rs1_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrun_busy", {31'h0, rs1_busy}, 32'h0);
    check("midrun_pend", {31'h0, pending_any}, 32'h0);
    check("midrun_ready", {31'h0, ready}, 32'h0);
    tick();
    release_and_init("init2");
    rs1_num = 5'd4;
    #1;
    check("x4_busy_after", {31'h0, rs1_busy}, 32'h0);
    check("x4_data_after", rs1_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_regfile.md
# scoreboard_regfile

Parametrised integer register file with a per-register pending scoreboard and a self-clearing reset sequence. It sits in the decode/writeback path of the core: decode reads two source operands and marks the destination pending at issue, and writeback stores the result and clears the pending bit. Hazard logic uses the busy flags to stall. An optional write-to-read bypass removes the one-cycle writeback bubble.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 4.
- AW, $clog2(NREGS), register-number width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rs1_num  in  AW  source register 1 number.
- rs2_num  in  AW  source register 2 number.
- rs1_data  out  XLEN  source 1 value, combinational.
- rs2_data  out  XLEN  source 2 value, combinational.
- rs1_busy  out  1  source 1 has an outstanding producer.
- rs2_busy  out  1  source 2 has an outstanding producer.
- iss_en  in  1  issue strobe: mark iss_num pending.
- iss_num  in  AW  destination register of the issuing instruction.
- wr_en  in  1  writeback strobe.
- rd_num  in  AW  writeback destination register.
- wr_data  in  XLEN  writeback value.
- ready  out  1  initialisation complete; writes and issues are accepted only when ready=1.
- pending_any  out  1  OR of all pending bits.

Clock port is clk. Reset is rst_n: asynchronous, active-low.

## Operation
- State machine with states INIT and RUN. rst_n=0 forces INIT, clr_cnt=0, and all pending bits to 0, asynchronously.
- INIT: each cycle, entry clr_cnt is written with 0 and clr_cnt increments. At clr_cnt==NREGS-1 the entry is written and the state moves to RUN. wr_en and iss_en are ignored. rs*_data=0, rs*_busy=0.
- RUN: no exit except reset.
- Register 0 is hardwired zero:
  - Reads of register 0 return 0 and busy=0.
  - wr_en with rd_num=0 is dropped.
  - iss_en with iss_num=0 sets nothing.
- Write: in RUN, when wr_en=1 and rd_num!=0, regs[rd_num] <= wr_data and pending[rd_num] <= 0.
- Issue: in RUN, when iss_en=1 and iss_num!=0, pending[iss_num] <= 1.
- If iss_en and wr_en target the same register in the same cycle, the data is written and pending ends at 1 (the set wins, because a new producer was issued).
- rsN_busy = pending[rsN_num] in RUN (subject to bypass, see Configuration).
- pending_any is the registered-state OR and reflects the bits after the last edge.

## Timing
- Reset values: ready=0, pending_any=0, rs*_busy=0, rs*_data=0.
- The first edge after rst_n deasserts clears entry 0. ready rises after exactly NREGS rising edges, i.e. ready=1 in cycle NREGS.
- Write latency: without bypass, a read of the same register returns the new value in the cycle after the wr_en edge.
- Issue latency: busy is visible in the cycle after the iss_en edge.
- Reset mid-INIT or mid-RUN restarts the clear from entry 0 and drops all pending bits.
- No handshake backpressure: every strobe in RUN is accepted in its cycle.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, when wr_en=1, rd_num==rsN_num and rd_num!=0:
  - rsN_data = wr_data in the same cycle.
  - rsN_busy = 0, unless iss_en targets the same register in that cycle, in which case busy stays at the pending value.
- REGFILE_BYPASS_EN undefined: reads always come from array state, and rsN_busy = pending[rsN_num]. The same-cycle reader sees the old value and busy=1.

## Test plan
- Reset with NREGS=32, hold rst_n=0 for 3 cycles, then release: ready=0 for 32 cycles and 1 at cycle 32; every register reads 0; pending_any=0.
- In RUN, write 0xDEADBEEF to x5 and 0x12345678 to x0: x5 reads 0xDEADBEEF on the next cycle; x0 reads 0.
- iss_en on x7, then wr_en x7=0xA5A5A5A5 three cycles later: rs1_busy=1 and pending_any=1 in between; both drop to 0 after the write edge; the value reads back.
- Same-cycle iss_en and wr_en on x9 with 0x55: data reads 0x55 and rs1_busy stays 1.
- Bypass on: wr_en x3=0x77 with rs2_num=3 in the same cycle gives rs2_data=0x77 and rs2_busy=0 combinationally. Bypass off: the old value and busy=1.
- Assert rst_n=0 at INIT clr_cnt=10 and at RUN with x4 pending: both restart the clear from entry 0; x4 is not busy; ready returns 32 cycles after release.
